// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler
//   Sits between fetch and the core's instruction input for the QED (EDDI-V)
//   flow.
//   ORIG mode: eligible instructions pass through and are queued. Ineligible
//              instructions are replaced by a NOP.
//   DUP mode:  the queue is drained and register-remapped duplicates are
//              issued.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous active-low reset
//   exec_dup   : level request to switch to DUP mode
//   in_instr   : fetched instruction
//   in_valid   : in_instr is valid
//   in_ready   : in_instr is accepted this cycle
//   out_instr  : instruction to the core
//   out_valid  : out_instr is valid
//   out_ready  : the core accepts out_instr
//   out_is_dup : out_instr is a duplicate
//   num_orig   : count of eligible originals issued (wraps)
//   num_dup    : count of duplicates issued (wraps)
//   qed_ready  : one-cycle strobe; the drain is complete and the counts match
//
// Optional build macro
//   QED_MEM_OFFSET_EN : duplicate LW/SW immediates get MEM_OFFSET added
//                       (12-bit wrap). When the macro is undefined, the
//                       immediates are copied unchanged.
module qed_dup_scheduler #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned REG_OFFSET = 16,
  parameter int unsigned CNT_W      = 16,
  parameter logic [11:0] MEM_OFFSET = 12'h400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_dup,
  input  logic [31:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_dup,
  output logic [CNT_W-1:0] num_orig,
  output logic [CNT_W-1:0] num_dup,
  output logic             qed_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [4:0]  ROFF = 5'(REG_OFFSET);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef QED_MEM_OFFSET_EN
  localparam logic MEM_EN = 1'b1;
`else
  localparam logic MEM_EN = 1'b0;
`endif
  // A zero offset leaves the immediates unchanged, so both builds share one
  // transform path.
  localparam logic [11:0] DUP_MEM_OFF = MEM_OFFSET & {12{MEM_EN}};

  typedef enum logic {S_ORIG, S_DUP} state_t;

  function automatic logic f_reg_ok(input logic [4:0] r);
    return 32'(r) < REG_OFFSET;
  endfunction

  function automatic logic f_eligible(input logic [31:0] ins);
    logic rd_ok, rs1_ok, rs2_ok, ok;
    rd_ok  = f_reg_ok(ins[11:7]);
    rs1_ok = f_reg_ok(ins[19:15]);
    rs2_ok = f_reg_ok(ins[24:20]);
    case (ins[6:0])
      OP_R:             ok = rd_ok && rs1_ok && rs2_ok;
      OP_I, OP_LW:      ok = rd_ok && rs1_ok;
      OP_SW:            ok = rs1_ok && rs2_ok;
      OP_LUI, OP_AUIPC: ok = rd_ok;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [4:0] f_remap(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : r + ROFF;
  endfunction

  function automatic logic [31:0] f_dup(input logic [31:0] ins);
    logic [31:0] d;
    logic [11:0] imm;
    d = ins;
    case (ins[6:0])
      OP_R: begin
        d[11:7]  = f_remap(ins[11:7]);
        d[19:15] = f_remap(ins[19:15]);
        d[24:20] = f_remap(ins[24:20]);
      end
      OP_I: begin
        d[11:7]  = f_remap(ins[11:7]);
        d[19:15] = f_remap(ins[19:15]);
      end
      OP_LW: begin
        d[11:7]  = f_remap(ins[11:7]);
        d[19:15] = f_remap(ins[19:15]);
        d[31:20] = ins[31:20] + DUP_MEM_OFF;
      end
      OP_SW: begin
        // bits [11:7] hold imm[4:0] here, not rd
        d[19:15] = f_remap(ins[19:15]);
        d[24:20] = f_remap(ins[24:20]);
        imm      = {ins[31:25], ins[11:7]} + DUP_MEM_OFF;
        d[31:25] = imm[11:5];
        d[11:7]  = imm[4:0];
      end
      OP_LUI, OP_AUIPC: d[11:7] = f_remap(ins[11:7]);
      default: d = ins;
    endcase
    return d;
  endfunction

  state_t           r_state, w_next;
  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_out_instr;
  logic             r_out_valid, r_out_is_dup, r_out_last, r_qed;
  logic [CNT_W-1:0] r_num_orig, r_num_dup;

  logic w_slot_free, w_in_elig, w_in_ready, w_accept, w_push, w_pop, w_final_pop;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_in_elig   = f_eligible(in_instr);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_ORIG;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_final_pop = 1'b0;
    case (r_state)
      S_ORIG: begin
        w_in_ready = w_slot_free && (r_count != CNT_FULL);
        w_accept   = in_valid && w_in_ready;
        w_push     = w_accept && w_in_elig;
        // An accept wins over exec_dup; the switch is re-evaluated next cycle.
        if ((exec_dup && (r_count != '0) && !w_accept) || (r_count == CNT_FULL))
          w_next = S_DUP;
      end
      S_DUP: begin
        w_pop       = w_slot_free && (r_count != '0);
        w_final_pop = w_pop && (r_count == CNT_ONE);
        if (w_final_pop || (r_count == '0))
          w_next = S_ORIG;
      end
      default: w_next = S_ORIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_instr  <= NOP;
      r_out_valid  <= 1'b0;
      r_out_is_dup <= 1'b0;
      r_out_last   <= 1'b0;
      r_num_orig   <= '0;
      r_num_dup    <= '0;
      r_qed        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= w_in_elig ? in_instr : NOP;
        r_out_is_dup <= 1'b0;
        r_out_last   <= 1'b0;
      end else if (w_pop) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= f_dup(r_mem[r_rd_ptr]);
        r_out_is_dup <= 1'b1;
        r_out_last   <= w_final_pop;
      end else if (w_slot_free) begin
        r_out_valid  <= 1'b0;
      end

      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_num_orig <= r_num_orig + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_num_dup <= r_num_dup + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      // Pulse the cycle after the core takes the final duplicate of a drain.
      r_qed <= r_out_valid && out_ready && r_out_last &&
               (r_num_orig == r_num_dup) && (r_num_orig != '0);
    end
  end

  assign in_ready   = w_in_ready;
  assign out_instr  = r_out_instr;
  assign out_valid  = r_out_valid;
  assign out_is_dup = r_out_is_dup;
  assign num_orig   = r_num_orig;
  assign num_dup    = r_num_dup;
  assign qed_ready  = r_qed;

endmodule
